sequence_detector: RTL and testbench

Serial-stream consumer placed directly downstream of the sequence generator.
- Watches a 1-bit serial stream for an 8-bit pattern (default 11010101, MSB first), with overlapping detection.
- Pulses `match` on each occurrence and keeps a saturating match count.
- Runs a frame-lock FSM (HUNT/VERIFY/LOCKED) that declares lock once the pattern repeats on consecutive 8-bit boundaries.

---
 rtl/seq_pkg.sv | 47 ++++
 rtl/seq_match_fsm.sv | 50 +++++
 rtl/sequence_detector.sv | 143 ++++++++++++++
 tb/tb_sequence_detector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence detector.
//   DEFAULT_PATTERN : 8-bit pattern, bit 7 received first
//   PAT_LEN         : pattern length in bits
//   lock_state_t    : frame-lock FSM states
//   match_state_t   : matcher states, one per matched prefix length
//   kmp_next()      : prefix-automaton transition used to build the matcher table
package seq_pkg;

  localparam int PAT_LEN = 8;
  localparam logic [PAT_LEN-1:0] DEFAULT_PATTERN = 8'b11010101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0, M1 = 3'd1, M2 = 3'd2, M3 = 3'd3,
    M4 = 3'd4, M5 = 3'd5, M6 = 3'd6, M7 = 3'd7
  } match_state_t;

  // Longest proper pattern prefix (length < PAT_LEN) that is a suffix of
  // (first 'state' pattern bits followed by b). A full match therefore lands
  // on the pattern's border, which is the restart point for overlapping hits.
  function automatic logic [2:0] kmp_next(input int state, input logic b,
                                          input logic [PAT_LEN-1:0] pat);
    logic [2:0] best;
    logic       ok;
    logic       sym;
    int         pos;
    best = '0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (k <= state + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          pos = state + 1 - k + j;
          sym = (pos == state) ? b : pat[PAT_LEN-1-pos];
          if (sym != pat[PAT_LEN-1-j]) ok = 1'b0;
        end
        if (ok) best = 3'(k);
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_match_fsm.sv
// Overlapping pattern matcher for a serial bit stream.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, returns to M0
//   in_valid : in_bit carries a stream bit this cycle
//   in_bit   : serial data bit
//   hit      : combinational, high in the valid cycle carrying the final pattern bit
//
// state | meaning
// M0-M7 | number of leading pattern bits currently matched
module seq_match_fsm
  import seq_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic hit
);

  match_state_t state;
  match_state_t state_next;
  match_state_t nxt_tbl [PAT_LEN][2];

  // Transition table derived from the pattern at elaboration.
  for (genvar s = 0; s < PAT_LEN; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam logic [2:0] NXT = kmp_next(s, 1'(b), PATTERN);
      assign nxt_tbl[s][b] = match_state_t'(NXT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= M0;
    end else if (in_valid) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = nxt_tbl[state][in_bit];
  end

  always_comb begin
    hit = in_valid && (state == M7) && (in_bit == PATTERN[0]);
  end

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector with match pulse, saturating match counter and
// frame-lock tracking.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   in_valid    : in_bit carries a stream bit this cycle
//   in_bit      : serial data bit
//   clear_count : synchronous clear of match_count, wins over a same-cycle hit
//   match       : one-cycle pulse after the valid bit completing the pattern
//   locked      : frame lock achieved
//   match_count : saturating count of matches
//
// state  | meaning
// HUNT   | no frame alignment, waiting for any hit
// VERIFY | candidate alignment, counting hits on consecutive frame boundaries
// LOCKED | aligned, counting consecutive boundary misses
module sequence_detector
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN  = seq_pkg::PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN  = DEFAULT_PATTERN,
  parameter int                 LOCK_N   = 3,
  parameter int                 UNLOCK_N = 2,
  parameter int                 CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_count,
  output logic             match,
  output logic             locked,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(PAT_LEN);
  localparam int CW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam int MW = (UNLOCK_N < 2) ? 1 : $clog2(UNLOCK_N + 1);

  logic          hit;
  lock_state_t   lock_state, lock_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic [CW-1:0] confirm, confirm_next, confirm_inc;
  logic [MW-1:0] miss, miss_next, miss_inc;
  logic          boundary;

  seq_match_fsm #(
    .PATTERN (PATTERN)
  ) u_match (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .hit      (hit)
  );

  // frame_cnt is 0 on the first bit after an alignment point, so the
  // PAT_LEN-th valid bit is the next boundary.
  assign boundary    = (frame_cnt == FW'(PAT_LEN - 1));
  assign confirm_inc = confirm + CW'(1);
  assign miss_inc    = miss + MW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state <= HUNT;
      frame_cnt  <= '0;
      confirm    <= '0;
      miss       <= '0;
      match      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      lock_state <= lock_next;
      frame_cnt  <= frame_next;
      confirm    <= confirm_next;
      miss       <= miss_next;
      match      <= hit;
      locked     <= (lock_next == LOCKED);
    end
  end

  always_comb begin
    lock_next    = lock_state;
    frame_next   = frame_cnt;
    confirm_next = confirm;
    miss_next    = miss;
    if (in_valid) begin
      unique case (lock_state)
        HUNT: begin
          if (hit) begin
            frame_next = '0;
            miss_next  = '0;
            if (LOCK_N == 1) begin
              lock_next = LOCKED;
            end else begin
              lock_next    = VERIFY;
              confirm_next = CW'(1);
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            frame_next = '0;
            if (hit) begin
              confirm_next = confirm_inc;
              if (confirm_inc == CW'(LOCK_N)) begin
                lock_next = LOCKED;
                miss_next = '0;
              end
            end else begin
              lock_next = HUNT;
            end
          end else begin
            frame_next = frame_cnt + FW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            frame_next = '0;
            if (hit) begin
              miss_next = '0;
            end else begin
              miss_next = miss_inc;
              if (miss_inc == MW'(UNLOCK_N)) lock_next = HUNT;
            end
          end else begin
            frame_next = frame_cnt + FW'(1);
          end
        end
        default: lock_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (hit && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector: directed scenarios plus random
// stream, all compared against a history-window reference model.
module tb_sequence_detector;

  localparam int         CNT_W    = 8;
  localparam int         LOCK_N   = 3;
  localparam int         UNLOCK_N = 2;
  localparam logic [7:0] PAT      = 8'b11010101;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear_count = 1'b0;
  logic             match;
  logic             locked;
  logic [CNT_W-1:0] match_count;

  always #5 clk = ~clk;

  sequence_detector #(
    .PAT_LEN  (8),
    .PATTERN  (PAT),
    .LOCK_N   (LOCK_N),
    .UNLOCK_N (UNLOCK_N),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .match       (match),
    .locked      (locked),
    .match_count (match_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: last 8 valid bits, valid-bit index, lock mode with an
  // anchor index from which frame boundaries are every 8 valid bits.
  logic [7:0] hist;
  int         nvalid;
  int         m_count;
  int         m_mode;     // 0 hunt, 1 verify, 2 locked
  int         anchor;
  int         confirms;
  int         misses;
  bit         m_match;
  bit         m_locked;

  task automatic model_reset();
    hist     = '0;
    nvalid   = 0;
    m_count  = 0;
    m_mode   = 0;
    anchor   = 0;
    confirms = 0;
    misses   = 0;
    m_match  = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit hit;
    hit = 1'b0;
    if (v) begin
      hist   = {hist[6:0], b};
      nvalid = nvalid + 1;
      hit    = (nvalid >= 8) && (hist == PAT);
    end
    if (clr) m_count = 0;
    else if (hit && (m_count < (1 << CNT_W) - 1)) m_count = m_count + 1;
    if (v) begin
      if (m_mode == 0) begin
        if (hit) begin
          anchor = nvalid;
          misses = 0;
          if (LOCK_N == 1) m_mode = 2;
          else begin
            m_mode   = 1;
            confirms = 1;
          end
        end
      end else if (((nvalid - anchor) % 8) == 0) begin
        if (m_mode == 1) begin
          if (hit) begin
            confirms = confirms + 1;
            if (confirms == LOCK_N) begin
              m_mode = 2;
              misses = 0;
            end
          end else begin
            m_mode = 0;
          end
        end else begin
          if (hit) misses = 0;
          else begin
            misses = misses + 1;
            if (misses == UNLOCK_N) m_mode = 0;
          end
        end
      end
    end
    m_match  = hit;
    m_locked = (m_mode == 2);
  endtask

  task automatic drive(input bit v, input bit b, input bit clr);
    in_valid    = v;
    in_bit      = b;
    clear_count = clr;
    @(posedge clk);
    #1;
    model_step(v, b, clr);
    check("match", match, m_match);
    check("locked", locked, m_locked);
    check("match_count", match_count, m_count);
  endtask

  task automatic do_reset();
    in_valid    = 1'b0;
    clear_count = 1'b0;
    reset       = 1'b1;
    #1;
    check("rst_match", match, 0);
    check("rst_locked", locked, 0);
    check("rst_count", match_count, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_count", match_count, 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send_bits(input logic [7:0] p, input int nbits, input int maxgap);
    logic [7:0] pv;
    pv = p;
    for (int i = 7; i > 7 - nbits; i--) begin
      repeat ($urandom_range(0, maxgap)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      drive(1'b1, pv[i], 1'b0);
    end
  endtask

  initial begin
    logic [7:0]  bad;
    logic [14:0] two;
    int          r;

    model_reset();
    @(posedge clk);
    #1;

    // single pattern
    do_reset();
    send_bits(PAT, 8, 0);
    check("t1_pulse", match, 1);
    check("t1_count", match_count, 1);
    check("t1_locked", locked, 0);
    drive(1'b0, 1'b0, 1'b0);

    // overlapping occurrence sharing one bit
    do_reset();
    two = 15'b110101011010101;
    for (int i = 14; i >= 0; i--) drive(1'b1, two[i], 1'b0);
    check("t2_count", match_count, 2);

    // lock after three aligned frames, unlock after two corrupted frames
    do_reset();
    bad = PAT ^ 8'h01;
    send_bits(PAT, 8, 0);
    send_bits(PAT, 8, 0);
    send_bits(PAT, 7, 0);
    check("t3_not_yet", locked, 0);
    send_bits({PAT[0], 7'b0}, 1, 0);
    check("t3_locked", locked, 1);
    send_bits(bad, 8, 0);
    send_bits(bad, 7, 0);
    check("t3_still", locked, 1);
    send_bits({bad[0], 7'b0}, 1, 0);
    check("t3_unlocked", locked, 0);

    // gaps of invalid cycles
    do_reset();
    send_bits(PAT, 8, 3);
    check("t4_count", match_count, 1);

    // reset mid-pattern
    do_reset();
    send_bits(PAT, 5, 0);
    do_reset();
    send_bits(PAT, 3, 0);
    check("t5_partial", match_count, 0);
    do_reset();
    send_bits(PAT, 8, 0);
    check("t5_count", match_count, 1);

    // saturation and clear priority
    do_reset();
    for (int n = 0; n < 260; n++) send_bits(PAT, 8, 0);
    check("t6_sat", match_count, 255);
    send_bits(PAT, 7, 0);
    drive(1'b1, PAT[0], 1'b1);
    check("t6_clear", match_count, 0);
    send_bits(PAT, 8, 0);
    check("t6_after", match_count, 1);

    // random stream
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) do_reset();
      else if (r < 12) send_bits(PAT, 8, 1);
      else if (r < 16) begin
        repeat ($urandom_range(3, 5)) send_bits(PAT, 8, 0);
        if ($urandom_range(0, 1) == 1) begin
          bad = PAT ^ 8'(1 << $urandom_range(0, 7));
          send_bits(bad, 8, 0);
        end
      end else begin
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
